// File: rtl/ex_hazard_controller_pkg.sv
// ----------------------------------------------------------------------------
// ex_hazard_controller_pkg
// Shared constants for the execute-stage hazard controller:
//   FWD_*      ALU operand forwarding select encodings
//   XZR        zero register index, never a forwarding or hazard source
//   hz_state_e stall sequencer state encoding
// ----------------------------------------------------------------------------
package ex_hazard_controller_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/ex_hazard_controller_forward_select.sv
// ----------------------------------------------------------------------------
// ex_hazard_controller_forward_select
// Combinational forwarding priority for one ALU operand.
//   src_reg          source register read by the execute-stage instruction
//   ex_mem_rd/_we    destination and write enable in EX/MEM (highest priority)
//   mem_wb_rd/_we    destination and write enable in MEM/WB
//   force_reg        keep the pipeline value (operand is an immediate)
//   fwd              select: FWD_EXMEM, FWD_MEMWB or FWD_REG
// ----------------------------------------------------------------------------
module ex_hazard_controller_forward_select
    import ex_hazard_controller_pkg::*;
(
    input  logic [4:0] src_reg,
    input  logic [4:0] ex_mem_rd,
    input  logic       ex_mem_we,
    input  logic [4:0] mem_wb_rd,
    input  logic       mem_wb_we,
    input  logic       force_reg,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_REG;
        if (!force_reg) begin
            // EX/MEM holds the younger result, so it wins over MEM/WB
            if (ex_mem_we && (ex_mem_rd != XZR) && (ex_mem_rd == src_reg))
                fwd = FWD_EXMEM;
            else if (mem_wb_we && (mem_wb_rd != XZR) && (mem_wb_rd == src_reg))
                fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ex_hazard_controller.sv
// ----------------------------------------------------------------------------
// ex_hazard_controller
// Execute-stage forwarding, load-use stall and branch flush control.
//   clk, rst_n                         pipeline clock, async active-low reset
//   IF_ID_rn/rm, IF_ID_uses_rm         decode-stage source registers
//   ID_EX_rn/rm/rd, ID_EX_ALUSrc,
//   ID_EX_MemRead                      execute-stage instruction fields
//   EX_MEM_rd/RegWrite,
//   MEM_WB_rd/RegWrite                 downstream writers
//   branch_taken                       taken branch resolved in MEM
//   forwardA, forwardB                 ALU operand selects
//   pc_write, if_id_write              front-end load enables
//   id_ex_bubble                       zero ID/EX control fields
//   flush_if_id/id_ex/ex_mem           squash younger pipeline registers
//   stall_count, flush_count           saturating event counters
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal flow; a load-use hazard bubbles the current cycle
// ST_STALL | extra bubbles for multi-cycle load stalls, rem counts down
// ----------------------------------------------------------------------------
module ex_hazard_controller
    import ex_hazard_controller_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rn,
    input  logic [4:0]       IF_ID_rm,
    input  logic             IF_ID_uses_rm,
    input  logic [4:0]       ID_EX_rn,
    input  logic [4:0]       ID_EX_rm,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_ALUSrc,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       EX_MEM_rd,
    input  logic [4:0]       MEM_WB_rd,
    input  logic             EX_MEM_RegWrite,
    input  logic             MEM_WB_RegWrite,
    input  logic             branch_taken,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    hz_state_e  state;
    logic [3:0] rem;
    logic       hz;
    logic       flush;

    ex_hazard_controller_forward_select u_fwd_a (
        .src_reg   (ID_EX_rn),
        .ex_mem_rd (EX_MEM_rd),
        .ex_mem_we (EX_MEM_RegWrite),
        .mem_wb_rd (MEM_WB_rd),
        .mem_wb_we (MEM_WB_RegWrite),
        .force_reg (1'b0),
        .fwd       (forwardA)
    );

    ex_hazard_controller_forward_select u_fwd_b (
        .src_reg   (ID_EX_rm),
        .ex_mem_rd (EX_MEM_rd),
        .ex_mem_we (EX_MEM_RegWrite),
        .mem_wb_rd (MEM_WB_rd),
        .mem_wb_we (MEM_WB_RegWrite),
        .force_reg (ID_EX_ALUSrc),
        .fwd       (forwardB)
    );

    assign hz = ID_EX_MemRead && (ID_EX_rd != XZR) &&
                ((ID_EX_rd == IF_ID_rn) || (IF_ID_uses_rm && (ID_EX_rd == IF_ID_rm)));

    // Control outputs are gated by rst_n so they show RUN values while reset
    // is held, even if branch_taken or a hazard is presented meanwhile.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        flush        = 1'b0;
        if (rst_n) begin
            if (branch_taken) begin
                flush = 1'b1;
            end else if ((state == ST_STALL) || hz) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    assign flush_if_id  = flush;
    assign flush_id_ex  = flush;
    assign flush_ex_mem = flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            rem         <= 4'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (branch_taken) begin
                state <= ST_RUN;
                rem   <= 4'd0;
            end else if (state == ST_STALL) begin
                // hz is ignored here so a repeated hazard cannot extend the stall
                if (rem <= 4'd1) begin
                    state <= ST_RUN;
                    rem   <= 4'd0;
                end else begin
                    rem <= rem - 4'd1;
                end
            end else if (hz && (LOAD_STALL_CYCLES > 1)) begin
                state <= ST_STALL;
                rem   <= 4'(LOAD_STALL_CYCLES - 1);
            end

            if (id_ex_bubble && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (branch_taken && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
